// File: rtl/tnoc_pkg.sv
// ---------------------------------------------------------------------------
// tnoc_pkg
// Shared flit definitions for the NoC receive path.
//   tnoc_flit_type_e : flit role inside a packet
//   tnoc_flit_t      : packed flit {flit_type, tail, payload}
//   FLIT_WIDTH       : $bits(tnoc_flit_t)
//   TAIL_BIT         : bit position of tnoc_flit_t.tail in the packed vector
// ---------------------------------------------------------------------------
package tnoc_pkg;

    localparam int PAYLOAD_WIDTH = 32;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } tnoc_flit_type_e;

    typedef struct packed {
        tnoc_flit_type_e            flit_type;
        logic                       tail;
        logic [PAYLOAD_WIDTH-1:0]   payload;
    } tnoc_flit_t;

    localparam int FLIT_WIDTH = $bits(tnoc_flit_t);

    // payload occupies the low bits, so tail sits just above it
    localparam int TAIL_BIT = PAYLOAD_WIDTH;

endpackage

// File: rtl/tnoc_flit_fifo_storage.sv
// ---------------------------------------------------------------------------
// tnoc_flit_fifo_storage
// DEPTH x WIDTH flit array with write/read pointers. Occupancy tracking and
// flow control live in the parent; this block only writes on wr_en_i,
// advances the read pointer on rd_en_i and presents the head entry.
// Ports:
//   clk       in   clock
//   rst_n     in   async active-low reset (pointers only, array not reset)
//   wr_en_i   in   write wr_data_i at write pointer
//   wr_data_i in   flit to store
//   rd_en_i   in   advance read pointer
//   rd_data_o out  flit at read pointer (combinational read)
// ---------------------------------------------------------------------------
module tnoc_flit_fifo_storage
    import tnoc_pkg::*;
#(
    parameter int WIDTH = FLIT_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/tnoc_flit_receive_buffer.sv
// ---------------------------------------------------------------------------
// tnoc_flit_receive_buffer
// Receive-side flit FIFO. Accepts flits from upstream on valid/ready,
// replays them downstream in order and advertises space via i_vc_available.
// Ports:
//   clk, rst_n        clock / async active-low reset
//   i_valid, i_flit   upstream flit offer
//   i_ready           registered: at least one free entry
//   i_vc_available    registered: at least VC_THRESHOLD free entries
//   o_valid, o_flit   downstream flit offer (head of FIFO)
//   o_ready           downstream accept
//   o_flit_count      occupied entries
//   o_packet_count    buffered tail flits (complete packets)
// Optional feature macro: TNOC_RECEIVE_BUFFER_STORE_AND_FORWARD_EN
//   defined   : a packet is offered only once its tail is buffered
//   undefined : cut-through, any buffered flit is offered
// ---------------------------------------------------------------------------
module tnoc_flit_receive_buffer
    import tnoc_pkg::TAIL_BIT;
#(
    parameter int FLIT_WIDTH   = tnoc_pkg::FLIT_WIDTH,
    parameter int DEPTH        = 8,
    parameter int VC_THRESHOLD = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic [FLIT_WIDTH-1:0]        i_flit,
    output logic                         i_vc_available,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [FLIT_WIDTH-1:0]        o_flit,
    output logic [$clog2(DEPTH+1)-1:0]   o_flit_count,
    output logic [$clog2(DEPTH+1)-1:0]   o_packet_count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [CW-1:0] flit_count_q;
    logic [CW-1:0] flit_count_d;
    logic [CW-1:0] packet_count_q;
    logic [CW-1:0] packet_count_d;
    logic [CW-1:0] free_d;
    logic          i_ready_q;
    logic          vc_available_q;
    logic          push;
    logic          pop;
    logic          push_tail;
    logic          pop_tail;
    logic          out_valid;

    // i_ready is the registered flag, so a pop on a full buffer cannot
    // open a slot for a push in the same cycle
    assign push      = i_valid & i_ready_q;
    assign pop       = out_valid & o_ready;
    assign push_tail = push & i_flit[TAIL_BIT];
    assign pop_tail  = pop & o_flit[TAIL_BIT];

    always_comb begin
        flit_count_d   = flit_count_q + CW'(push) - CW'(pop);
        packet_count_d = packet_count_q + CW'(push_tail) - CW'(pop_tail);
        free_d         = CW'(DEPTH) - flit_count_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_count_q   <= '0;
            packet_count_q <= '0;
            i_ready_q      <= 1'b0;
            vc_available_q <= 1'b0;
        end else begin
            flit_count_q   <= flit_count_d;
            packet_count_q <= packet_count_d;
            i_ready_q      <= (free_d != '0);
            vc_available_q <= (free_d >= CW'(VC_THRESHOLD));
        end
    end

`ifdef TNOC_RECEIVE_BUFFER_STORE_AND_FORWARD_EN
    // set once a packet has started leaving, so its remaining flits keep
    // flowing even though its tail may be the only one left in the count
    logic in_packet_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_packet_out_q <= 1'b0;
        end else if (pop) begin
            in_packet_out_q <= !o_flit[TAIL_BIT];
        end
    end

    assign out_valid = (flit_count_q != '0) &
                       ((packet_count_q != '0) | in_packet_out_q);

    // a packet longer than DEPTH would fill the buffer with no tail present
    // and deadlock the output
    a_packet_fits: assert property (@(posedge clk) disable iff (!rst_n)
        !((flit_count_q == CW'(DEPTH)) && (packet_count_q == '0) && !in_packet_out_q));
`else
    assign out_valid = (flit_count_q != '0);
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (flit_count_q <= CW'(DEPTH)) && (packet_count_q <= flit_count_q));

    tnoc_flit_fifo_storage #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (push),
        .wr_data_i (i_flit),
        .rd_en_i   (pop),
        .rd_data_o (o_flit)
    );

    assign i_ready        = i_ready_q;
    assign i_vc_available = vc_available_q;
    assign o_valid        = out_valid;
    assign o_flit_count   = flit_count_q;
    assign o_packet_count = packet_count_q;

endmodule

// File: tb/tb_tnoc_flit_receive_buffer.sv
module tb_tnoc_flit_receive_buffer;
    import tnoc_pkg::*;

    localparam int DEPTH = 8;
    localparam int VCT   = 4;
    localparam int W     = FLIT_WIDTH;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          i_ready;
    logic [W-1:0]  i_flit;
    logic          i_vc_available;
    logic          o_valid;
    logic          o_ready;
    logic [W-1:0]  o_flit;
    logic [CW-1:0] o_flit_count;
    logic [CW-1:0] o_packet_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tnoc_flit_receive_buffer #(
        .FLIT_WIDTH   (W),
        .DEPTH        (DEPTH),
        .VC_THRESHOLD (VCT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_valid        (i_valid),
        .i_ready        (i_ready),
        .i_flit         (i_flit),
        .i_vc_available (i_vc_available),
        .o_valid        (o_valid),
        .o_ready        (o_ready),
        .o_flit         (o_flit),
        .o_flit_count   (o_flit_count),
        .o_packet_count (o_packet_count)
    );

    // reference model: queue of buffered flits
    logic [W-1:0] model_q[$];
    bit           model_rdy_en = 1'b0;
    bit           model_in_pkt = 1'b0;

    function automatic logic [W-1:0] make_flit(tnoc_flit_type_e t, logic tl, logic [PAYLOAD_WIDTH-1:0] p);
        tnoc_flit_t f;
        f.flit_type = t;
        f.tail      = tl;
        f.payload   = p;
        return f;
    endfunction

    function automatic bit is_tail(logic [W-1:0] v);
        tnoc_flit_t f;
        f = v;
        return f.tail;
    endfunction

    function automatic int model_tails();
        int n = 0;
        foreach (model_q[k]) if (is_tail(model_q[k])) n++;
        return n;
    endfunction

    function automatic bit exp_ready();
        return model_rdy_en && (model_q.size() < DEPTH);
    endfunction

    function automatic bit exp_vc();
        return model_rdy_en && ((DEPTH - model_q.size()) >= VCT);
    endfunction

    function automatic bit exp_valid();
`ifdef TNOC_RECEIVE_BUFFER_STORE_AND_FORWARD_EN
        return (model_q.size() != 0) && ((model_tails() != 0) || model_in_pkt);
`else
        return model_q.size() != 0;
`endif
    endfunction

    // drive one cycle of stimulus and advance the model; called at posedge+1
    task automatic cycle(input logic v, input logic [W-1:0] f, input logic ordy);
        bit pu, po;
        i_valid = v;
        i_flit  = f;
        o_ready = ordy;
        pu = v && exp_ready();
        po = exp_valid() && ordy;
        @(posedge clk);
        #1;
        if (po) begin
            model_in_pkt = !is_tail(model_q[0]);
            void'(model_q.pop_front());
        end
        if (pu) model_q.push_back(f);
        model_rdy_en = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b0;
    endtask

    task automatic model_reset();
        model_q.delete();
        model_rdy_en = 1'b0;
        model_in_pkt = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        i_flit  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL reset_i_ready got=%b exp=0", i_ready); end
        checks++; if (i_vc_available !== 1'b0) begin failures++; $display("FAIL reset_vc got=%b exp=0", i_vc_available); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
        checks++; if (o_flit_count !== '0) begin failures++; $display("FAIL reset_flit_count got=%0d exp=0", o_flit_count); end
        checks++; if (o_packet_count !== '0) begin failures++; $display("FAIL reset_packet_count got=%0d exp=0", o_packet_count); end
        rst_n = 1'b1;
        checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL release_i_ready_before_edge got=%b exp=0", i_ready); end
        cycle(1'b0, '0, 1'b0);
        checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL release_i_ready got=%b exp=1", i_ready); end
        checks++; if (i_vc_available !== 1'b1) begin failures++; $display("FAIL release_vc got=%b exp=1", i_vc_available); end
    endtask

    task automatic drain_model(input int budget);
        int n = 0;
        while (model_q.size() != 0 && n < budget) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
    endtask

    task automatic test_partial_fill();
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, make_flit(FLIT_SINGLE, 1'b1, PAYLOAD_WIDTH'(32'h100 + k)), 1'b0);
            checks++; if (o_flit_count !== CW'(k)) begin failures++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, o_flit_count, k); end
            checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL fill_i_ready k=%0d got=%b exp=1", k, i_ready); end
            checks++; if (i_vc_available !== (k <= DEPTH - VCT)) begin failures++; $display("FAIL fill_vc k=%0d got=%b exp=%b", k, i_vc_available, (k <= DEPTH - VCT)); end
        end
        checks++; if (o_flit !== make_flit(FLIT_SINGLE, 1'b1, PAYLOAD_WIDTH'(32'h101))) begin failures++; $display("FAIL fill_head got=%h", o_flit); end
        drain_model(20);
        checks++; if (o_flit_count !== '0) begin failures++; $display("FAIL fill_drain_count got=%0d exp=0", o_flit_count); end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] exp_f[DEPTH];
        for (int k = 0; k < DEPTH; k++) begin
            exp_f[k] = make_flit(FLIT_SINGLE, 1'b1, $urandom());
            cycle(1'b1, exp_f[k], 1'b0);
        end
        checks++; if (o_flit_count !== CW'(DEPTH)) begin failures++; $display("FAIL full_count got=%0d exp=%0d", o_flit_count, DEPTH); end
        checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL full_i_ready got=%b exp=0", i_ready); end
        checks++; if (i_vc_available !== 1'b0) begin failures++; $display("FAIL full_vc got=%b exp=0", i_vc_available); end
        checks++; if (o_packet_count !== CW'(DEPTH)) begin failures++; $display("FAIL full_pkt got=%0d exp=%0d", o_packet_count, DEPTH); end
        cycle(1'b1, make_flit(FLIT_SINGLE, 1'b1, 32'hDEAD_BEEF), 1'b1);
        checks++; if (o_flit_count !== CW'(DEPTH-1)) begin failures++; $display("FAIL fullpp_count got=%0d exp=%0d", o_flit_count, DEPTH-1); end
        checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL fullpp_i_ready got=%b exp=1", i_ready); end
        for (int k = 1; k < DEPTH; k++) begin
            checks++; if (o_valid !== 1'b1 || o_flit !== exp_f[k]) begin failures++; $display("FAIL full_order k=%0d got=%b/%h exp=1/%h", k, o_valid, o_flit, exp_f[k]); end
            cycle(1'b0, '0, 1'b1);
        end
        checks++; if (o_valid !== 1'b0 || o_flit_count !== '0) begin failures++; $display("FAIL full_drain got=%b/%0d exp=0/0", o_valid, o_flit_count); end
    endtask

    task automatic test_random_stream();
        logic [W-1:0] src[$];
        logic [W-1:0] prev_flit = '0;
        bit           prev_stall = 1'b0;
        int           total = 0, n_out = 0, cyc = 0, bad = 0;
        for (int p = 0; p < 200; p++) begin
            int len = int'($urandom_range(1, 6));
            for (int k = 0; k < len; k++) begin
                tnoc_flit_type_e t;
                if (len == 1)          t = FLIT_SINGLE;
                else if (k == 0)       t = FLIT_HEAD;
                else if (k == len - 1) t = FLIT_TAIL;
                else                   t = FLIT_BODY;
                src.push_back(make_flit(t, (k == len - 1), $urandom()));
                total++;
            end
        end
        while ((src.size() != 0 || model_q.size() != 0) && cyc < 20000) begin
            logic         v, ordy;
            logic [W-1:0] f;
            bit           will_push;
            if (i_ready !== exp_ready() || o_valid !== exp_valid() || i_vc_available !== exp_vc() ||
                o_flit_count !== CW'(model_q.size()) || o_packet_count !== CW'(model_tails())) begin
                bad++;
                if (bad <= 5) $display("FAIL rand_state cyc=%0d got rdy=%b vld=%b vc=%b cnt=%0d pkt=%0d exp rdy=%b vld=%b vc=%b cnt=%0d pkt=%0d",
                    cyc, i_ready, o_valid, i_vc_available, o_flit_count, o_packet_count,
                    exp_ready(), exp_valid(), exp_vc(), model_q.size(), model_tails());
            end
            if (exp_valid() && o_flit !== model_q[0]) begin
                bad++;
                if (bad <= 5) $display("FAIL rand_flit cyc=%0d got=%h exp=%h", cyc, o_flit, model_q[0]);
            end
            if (prev_stall && o_flit !== prev_flit) begin
                bad++;
                if (bad <= 5) $display("FAIL rand_stall_stable cyc=%0d got=%h exp=%h", cyc, o_flit, prev_flit);
            end
            v    = (src.size() != 0) && ($urandom_range(0, 9) < 7);
            f    = v ? src[0] : W'($urandom());
            ordy = ($urandom_range(0, 9) < 6);
            will_push = v && exp_ready();
            if (o_valid === 1'b1 && ordy) n_out++;
            prev_stall = (o_valid === 1'b1) && !ordy;
            prev_flit  = o_flit;
            cycle(v, f, ordy);
            if (will_push) void'(src.pop_front());
            cyc++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rand_stream errors=%0d exp=0", bad); end
        checks++; if (cyc >= 20000) begin failures++; $display("FAIL rand_timeout cycles=%0d limit=20000", cyc); end
        checks++; if (n_out != total) begin failures++; $display("FAIL rand_flits_out got=%0d exp=%0d", n_out, total); end
        checks++; if (o_flit_count !== '0 || o_packet_count !== '0) begin failures++; $display("FAIL rand_end_counts got=%0d/%0d exp=0/0", o_flit_count, o_packet_count); end
    endtask

`ifdef TNOC_RECEIVE_BUFFER_STORE_AND_FORWARD_EN
    task automatic test_store_and_forward();
        logic [W-1:0] pk[4];
        pk[0] = make_flit(FLIT_HEAD, 1'b0, 32'hA0);
        pk[1] = make_flit(FLIT_BODY, 1'b0, 32'hA1);
        pk[2] = make_flit(FLIT_BODY, 1'b0, 32'hA2);
        pk[3] = make_flit(FLIT_TAIL, 1'b1, 32'hA3);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, pk[k], 1'b1);
            checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL saf_hold k=%0d got=%b exp=0", k, o_valid); end
        end
        cycle(1'b1, pk[3], 1'b1);
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL saf_release got=%b exp=1", o_valid); end
        checks++; if (o_packet_count !== CW'(1)) begin failures++; $display("FAIL saf_pkt got=%0d exp=1", o_packet_count); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (o_valid !== 1'b1 || o_flit !== pk[k]) begin failures++; $display("FAIL saf_out k=%0d got=%b/%h exp=1/%h", k, o_valid, o_flit, pk[k]); end
            cycle(1'b0, '0, 1'b1);
        end
        checks++; if (o_valid !== 1'b0 || o_flit_count !== '0) begin failures++; $display("FAIL saf_end got=%b/%0d exp=0/0", o_valid, o_flit_count); end
    endtask
`else
    task automatic test_cut_through();
        logic [W-1:0] h, t;
        h = make_flit(FLIT_HEAD, 1'b0, 32'hC0);
        t = make_flit(FLIT_TAIL, 1'b1, 32'hC1);
        cycle(1'b1, h, 1'b0);
        checks++; if (o_valid !== 1'b1 || o_flit !== h) begin failures++; $display("FAIL ct_head got=%b/%h exp=1/%h", o_valid, o_flit, h); end
        checks++; if (o_packet_count !== '0) begin failures++; $display("FAIL ct_pkt0 got=%0d exp=0", o_packet_count); end
        cycle(1'b1, t, 1'b0);
        checks++; if (o_packet_count !== CW'(1)) begin failures++; $display("FAIL ct_pkt1 got=%0d exp=1", o_packet_count); end
        cycle(1'b0, '0, 1'b1);
        checks++; if (o_flit !== t || o_packet_count !== CW'(1)) begin failures++; $display("FAIL ct_second got=%h/%0d exp=%h/1", o_flit, o_packet_count, t); end
        cycle(1'b0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0 || o_packet_count !== '0) begin failures++; $display("FAIL ct_end got=%b/%0d exp=0/0", o_valid, o_packet_count); end
    endtask
`endif

    task automatic test_reset_mid_packet();
        logic [W-1:0] h, t;
        for (int k = 0; k < 3; k++)
            cycle(1'b1, make_flit(k == 0 ? FLIT_HEAD : FLIT_BODY, 1'b0, PAYLOAD_WIDTH'(32'hE0 + k)), 1'b0);
        checks++; if (o_flit_count !== CW'(3)) begin failures++; $display("FAIL mid_count got=%0d exp=3", o_flit_count); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (o_flit_count !== '0 || o_packet_count !== '0) begin failures++; $display("FAIL mid_rst_counts got=%0d/%0d exp=0/0", o_flit_count, o_packet_count); end
        checks++; if (o_valid !== 1'b0 || i_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_flags got=%b/%b exp=0/0", o_valid, i_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b0);
        checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL mid_release_i_ready got=%b exp=1", i_ready); end
        h = make_flit(FLIT_HEAD, 1'b0, 32'hF0);
        t = make_flit(FLIT_TAIL, 1'b1, 32'hF1);
        cycle(1'b1, h, 1'b0);
        cycle(1'b1, t, 1'b0);
        checks++; if (o_valid !== 1'b1 || o_flit !== h || o_flit_count !== CW'(2)) begin failures++; $display("FAIL mid_next_head got=%b/%h/%0d exp=1/%h/2", o_valid, o_flit, o_flit_count, h); end
        cycle(1'b0, '0, 1'b1);
        checks++; if (o_flit !== t) begin failures++; $display("FAIL mid_next_tail got=%h exp=%h", o_flit, t); end
        cycle(1'b0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0 || o_packet_count !== '0) begin failures++; $display("FAIL mid_next_end got=%b/%0d exp=0/0", o_valid, o_packet_count); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        i_flit  = '0;
        test_reset();
        test_partial_fill();
        test_full_push_pop();
        test_random_stream();
`ifdef TNOC_RECEIVE_BUFFER_STORE_AND_FORWARD_EN
        test_store_and_forward();
`else
        test_cut_through();
`endif
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
